// File: rtl/rtc_sched_pkg.sv
// Shared types and constants for the RTC access scheduler.
// Defining RTC_CRONO_EN appends the three chronometer registers to the read sweep.
package rtc_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_WAIT,
        RD_ISSUE,
        RD_WAIT,
        PUBLISH
    } sched_state_e;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
    } bus_req_t;

    localparam logic [7:0] ADDR_SEG     = 8'h21;
    localparam logic [7:0] ADDR_MIN     = 8'h22;
    localparam logic [7:0] ADDR_HORA    = 8'h23;
    localparam logic [7:0] ADDR_DIA     = 8'h24;
    localparam logic [7:0] ADDR_MES     = 8'h25;
    localparam logic [7:0] ADDR_ANIO    = 8'h26;
    localparam logic [7:0] ADDR_SEG_CR  = 8'h41;
    localparam logic [7:0] ADDR_MIN_CR  = 8'h42;
    localparam logic [7:0] ADDR_HORA_CR = 8'h43;

`ifdef RTC_CRONO_EN
    localparam int unsigned SWEEP_LEN = 9;
`else
    localparam int unsigned SWEEP_LEN = 6;
`endif
    localparam int unsigned IDX_W = $clog2(SWEEP_LEN);

    // Sweep order; index 0 is read first.
    localparam logic [8:0][7:0] SWEEP_ADDRS = {ADDR_HORA_CR, ADDR_MIN_CR, ADDR_SEG_CR,
                                               ADDR_ANIO, ADDR_MES, ADDR_DIA,
                                               ADDR_HORA, ADDR_MIN, ADDR_SEG};

    function automatic logic [7:0] sweep_addr(input logic [3:0] idx);
        return SWEEP_ADDRS[idx];
    endfunction

endpackage

// File: rtl/rtc_bus_timer.sv
// Bus transaction watchdog: counts enabled cycles after a clear and flags the
// last cycle of the BUS_TIMEOUT window (BUS_TIMEOUT must be at least 2).
module rtc_bus_timer #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(BUS_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             expired_q;

    // expired_q is raised one cycle early so it lines up with wait-cycle BUS_TIMEOUT-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else if (clear) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else if (enable) begin
            cnt_q     <= cnt_q + CNT_W'(1);
            expired_q <= (cnt_q == CNT_W'(BUS_TIMEOUT - 2));
        end else begin
            expired_q <= 1'b0;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/rtc_access_scheduler.sv
// Arbitrates edit-controller writes against periodic time/date read sweeps on the
// RTC bus and publishes coherent snapshots. Optional feature macro: RTC_CRONO_EN.
module rtc_access_scheduler
    import rtc_sched_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rd_tick,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       bus_start,
    output logic       bus_wr,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    input  logic       bus_done,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] anio,
`ifdef RTC_CRONO_EN
    output logic [7:0] seg_cr,
    output logic [7:0] min_cr,
    output logic [7:0] hora_cr,
`endif
    output logic       snap_valid,
    output logic       busy,
    output logic       err
);

    typedef logic [SWEEP_LEN-1:0][7:0] snap_t;

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pend_q, pend_d;
    snap_t            stage_q, stage_d;
    snap_t            pub_q, pub_d;
    bus_req_t         bus_q, bus_d;
    logic             bus_start_q, bus_start_d;
    logic             wr_ack_q, wr_ack_d;
    logic             snap_q, snap_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             timer_clear_c, timer_en_c, timer_expired;

    assign timer_clear_c = (state_q == WR_ISSUE) || (state_q == RD_ISSUE);
    assign timer_en_c    = (state_q == WR_WAIT)  || (state_q == RD_WAIT);

    rtc_bus_timer #(
        .BUS_TIMEOUT(BUS_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear_c),
        .enable (timer_en_c),
        .expired(timer_expired)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pend_d      = pend_q | rd_tick;
        stage_d     = stage_q;
        pub_d       = pub_q;
        bus_d       = bus_q;
        bus_start_d = 1'b0;
        wr_ack_d    = 1'b0;
        snap_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The cycle right after wr_ack still sees the old wr_req level.
                if (wr_req && !wr_ack_q) begin
                    state_d     = WR_ISSUE;
                    bus_start_d = 1'b1;
                    bus_d       = '{wr: 1'b1, addr: wr_addr, wdata: wr_data};
                end else if (pend_q || (idx_q != '0)) begin
                    state_d     = RD_ISSUE;
                    bus_start_d = 1'b1;
                    bus_d       = '{wr: 1'b0, addr: sweep_addr(4'(idx_q)), wdata: 8'h00};
                    if (idx_q == '0) begin
                        pend_d = rd_tick;
                    end
                end
            end
            WR_ISSUE: state_d = WR_WAIT;
            RD_ISSUE: state_d = RD_WAIT;
            WR_WAIT: begin
                if (bus_done || timer_expired) begin
                    state_d  = IDLE;
                    wr_ack_d = 1'b1;
                    err_d    = !bus_done;
                end
            end
            RD_WAIT: begin
                if (bus_done || timer_expired) begin
                    if (bus_done) begin
                        stage_d[idx_q] = bus_rdata;
                    end
                    err_d = !bus_done;
                    // Publish on the way into PUBLISH so snap_valid follows the last bus_done directly.
                    if (idx_q == IDX_W'(SWEEP_LEN - 1)) begin
                        idx_d   = '0;
                        pub_d   = stage_d;
                        snap_d  = 1'b1;
                        state_d = PUBLISH;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = IDLE;
                    end
                end
            end
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pend_q      <= 1'b0;
            stage_q     <= '0;
            pub_q       <= '0;
            bus_q       <= '0;
            bus_start_q <= 1'b0;
            wr_ack_q    <= 1'b0;
            snap_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            stage_q     <= stage_d;
            pub_q       <= pub_d;
            bus_q       <= bus_d;
            bus_start_q <= bus_start_d;
            wr_ack_q    <= wr_ack_d;
            snap_q      <= snap_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign wr_ack     = wr_ack_q;
    assign bus_start  = bus_start_q;
    assign bus_wr     = bus_q.wr;
    assign bus_addr   = bus_q.addr;
    assign bus_wdata  = bus_q.wdata;
    assign snap_valid = snap_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign seg        = pub_q[0];
    assign min        = pub_q[1];
    assign hora       = pub_q[2];
    assign dia        = pub_q[3];
    assign mes        = pub_q[4];
    assign anio       = pub_q[5];
`ifdef RTC_CRONO_EN
    assign seg_cr     = pub_q[6];
    assign min_cr     = pub_q[7];
    assign hora_cr    = pub_q[8];
`endif

endmodule
